kogge_stone_sub_pipe: RTL and testbench

- Pipelined N-bit Kogge-Stone subtractor: computes A - B - Bin, the inverse operation of the team's Kogge-Stone adder.
- Uses the same parallel-prefix carry network, restructured into three registered stages with a valid/ready stream interface on each side.
- Intended as the subtract datapath for the ALU and as a reusable streaming arithmetic element.

---
 rtl/kogge_stone_sub_pipe.sv | 152 +++++++++++++++
 tb/tb_kogge_stone_sub_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kogge_stone_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: Diff = {0,A} - {0,B} - Bin, plus signed overflow.
// Bubble-collapsing valid/ready pipeline, 3-cycle latency, one operation per cycle.
module kogge_stone_sub_pipe #(
   parameter int N     = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   input  logic             Bin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N:0]       Diff,
   output logic             ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int L  = $clog2(N);
   localparam int L1 = (L + 1) / 2;

   // Prefix vectors span positions -1..N-1 at indices 0..N; index 0 holds carry_in.
   // Level L+1 (span N) only touches index N and yields the carry-out.
   function automatic logic [N:0] ks_p(input logic [N:0] p, input int lo, input int hi);
      logic [N:0] pc;
      logic [N:0] pn;
      pc = p;
      for (int d = 1; d <= L + 1; d++) begin
         if (d >= lo && d <= hi) begin
            pn = pc;
            for (int j = 1 << (d - 1); j <= N; j++)
               pn[j] = pc[j] & pc[j - (1 << (d - 1))];
            pc = pn;
         end
      end
      return pc;
   endfunction

   function automatic logic [N:0] ks_g(input logic [N:0] g, input logic [N:0] p,
                                       input int lo, input int hi);
      logic [N:0] gc;
      logic [N:0] pc;
      logic [N:0] gn;
      logic [N:0] pn;
      gc = g;
      pc = p;
      for (int d = 1; d <= L + 1; d++) begin
         if (d >= lo && d <= hi) begin
            gn = gc;
            pn = pc;
            for (int j = 1 << (d - 1); j <= N; j++) begin
               gn[j] = gc[j] | (pc[j] & gc[j - (1 << (d - 1))]);
               pn[j] = pc[j] & pc[j - (1 << (d - 1))];
            end
            gc = gn;
            pc = pn;
         end
      end
      return gc;
   endfunction

   logic             v1_q, v2_q, v3_q;
   logic             rdy1, rdy2, rdy3;
   logic [N:0]       g1_d, p1_d, g1_q, p1_q;
   logic [N:0]       g2_d, p2_d, g2_q, p2_q;
   logic [N-1:0]     ps2_q;
   logic             am2_q;
   logic [N:0]       g3;
   logic [N-1:0]     sum3;
   logic [N:0]       diff_d, diff_q;
   logic             ovf_d, ovf_q;
   logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

   assign rdy3     = !v3_q || out_ready;
   assign rdy2     = !v2_q || rdy3;
   assign rdy1     = !v1_q || rdy2;
   assign in_ready = rdy1;

   // Subtraction as A + ~B + !Bin.
   assign g1_d = {A & ~B, ~Bin};
   assign p1_d = {A ^ ~B, 1'b0};

   assign g2_d = ks_g(g1_q, p1_q, 1, L1);
   assign p2_d = ks_p(p1_q, 1, L1);

   assign g3     = ks_g(g2_q, p2_q, L1 + 1, L + 1);
   assign sum3   = ps2_q ^ g3[N-1:0];
   assign diff_d = {~g3[N], sum3};
   // MSBs differ exactly when p[N-1]=0, and then g[N-1] equals A[N-1].
   assign ovf_d  = ~ps2_q[N-1] & (sum3[N-1] ^ am2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         g1_q   <= '0;
         p1_q   <= '0;
         tag1_q <= '0;
      end else if (rdy1) begin
         v1_q <= in_valid;
         if (in_valid) begin
            g1_q   <= g1_d;
            p1_q   <= p1_d;
            tag1_q <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q   <= 1'b0;
         g2_q   <= '0;
         p2_q   <= '0;
         ps2_q  <= '0;
         am2_q  <= 1'b0;
         tag2_q <= '0;
      end else if (rdy2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            g2_q   <= g2_d;
            p2_q   <= p2_d;
            ps2_q  <= p1_q[N:1];
            am2_q  <= g1_q[N];
            tag2_q <= tag1_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_q   <= 1'b0;
         diff_q <= '0;
         ovf_q  <= 1'b0;
         tag3_q <= '0;
      end else if (rdy3) begin
         v3_q <= v2_q;
         if (v2_q) begin
            diff_q <= diff_d;
            ovf_q  <= ovf_d;
            tag3_q <= tag2_q;
         end
      end
   end

   assign out_valid = v3_q;
   assign Diff      = diff_q;
   assign ovf       = ovf_q;
   assign out_tag   = tag3_q;

endmodule

// File: tb/tb_kogge_stone_sub_pipe.sv
// Directed bench for kogge_stone_sub_pipe (N=16): latency, arithmetic corners, backpressure, reset, random handshake.
`timescale 1ns/1ps
module tb_kogge_stone_sub_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A, B;
   logic        Bin;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] Diff;
   logic        ovf;
   logic [3:0]  out_tag;

   int checks   = 0;
   int failures = 0;
   int n_in     = 0;
   int n_out    = 0;
   logic mon_en = 1'b0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [3:0]  tag;
   } op_t;
   op_t sb[$];

   localparam int NV = 11;
   localparam logic [15:0] TA [NV] = '{16'h8000, 16'h7FFF, 16'h1234, 16'h1234, 16'hFFFF, 16'h0000,
                                        16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h5555};
   localparam logic [15:0] TB [NV] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h1234, 16'h0000, 16'hFFFF,
                                        16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h2AAA};
   localparam logic TBIN [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [16:0] TD [NV] = '{17'h07FFF, 17'h18000, 17'h1FFFF, 17'h00000, 17'h0FFFF, 17'h10000,
                                        17'h1FFFF, 17'h00000, 17'h1FFFF, 17'h00001, 17'h02AAA};
   localparam logic TO [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   kogge_stone_sub_pipe #(.N(16), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Bin(Bin), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .Diff(Diff), .ovf(ovf), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] mdiff(input logic [15:0] a, input logic [15:0] b, input logic bin);
      return {1'b0, a} - {1'b0, b} - {16'b0, bin};
   endfunction

   function automatic logic movf(input logic [15:0] a, input logic [15:0] b, input logic bin);
      logic [16:0] d;
      d = mdiff(a, b, bin);
      return (a[15] != b[15]) && (d[15] != a[15]);
   endfunction

   // Scoreboard: transfers sampled on the falling edge, ahead of the rising edge that completes them.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (in_valid && in_ready) begin
            sb.push_back('{a: A, b: B, bin: Bin, tag: in_tag});
            n_in++;
         end
         if (out_valid && out_ready) begin
            op_t e;
            n_out++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sb_diff", 32'(Diff), 32'(mdiff(e.a, e.b, e.bin)));
               chk("sb_ovf", 32'(ovf), 32'(movf(e.a, e.b, e.bin)));
               chk("sb_tag", 32'(out_tag), 32'(e.tag));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      A        = 'x;
      B        = 'x;
      Bin      = 1'bx;
      in_tag   = 'x;
   endtask

   // Present one op and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input logic [3:0] t);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      A        = a;
      B        = b;
      Bin      = bin;
      in_tag   = t;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         cyc();
      end
      chk("push_accept", 32'(acc), 32'd1);
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int next;
      int bad;
      int sent;
      logic acc;

      rst_n     = 1'b0;
      out_ready = 1'b1;
      idle_inputs();
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(Diff), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      cyc();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      cyc();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Single op: 0 - 1 -> all ones with borrow, visible two edges after acceptance.
      push_op(16'h0000, 16'h0001, 1'b0, 4'h5);
      chk("lat_e0_valid", 32'(out_valid), 32'd0);
      cyc();
      chk("lat_e1_valid", 32'(out_valid), 32'd0);
      cyc();
      chk("lat_e2_valid", 32'(out_valid), 32'd1);
      chk("lat_diff", 32'(Diff), 32'h1FFFF);
      chk("lat_ovf", 32'(ovf), 32'd0);
      chk("lat_tag", 32'(out_tag), 32'h5);
      cyc();
      chk("lat_e3_valid", 32'(out_valid), 32'd0);

      // Hand-computed corner vectors.
      for (int i = 0; i < NV; i++) begin
         push_op(TA[i], TB[i], TBIN[i], 4'(i));
         cyc();
         cyc();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_diff", i), 32'(Diff), 32'(TD[i]));
         chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(TO[i]));
      end
      cyc();
      chk("vec_empty", 32'(sb.size()), 32'd0);

      // Backpressure: stream with out_ready low; exactly 3 accepts before in_ready drops.
      out_ready = 1'b0;
      next = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1;
         A = 16'h1111 * 16'(next);
         B = 16'h0F0F + 16'(next);
         Bin = next[0];
         in_tag = 4'(next);
         @(negedge clk);
         if (in_ready) next++;
         cyc();
      end
      chk("bp_accepts", 32'(next), 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_tag", 32'(out_tag), 32'd0);
      chk("bp_hold_diff", 32'(Diff), 32'(mdiff(16'h0000, 16'h0F0F, 1'b0)));
      cyc();
      cyc();
      chk("bp_hold_tag2", 32'(out_tag), 32'd0);
      chk("bp_hold_diff2", 32'(Diff), 32'(mdiff(16'h0000, 16'h0F0F, 1'b0)));

      // Release: full-rate push and pop for 100 cycles with no gaps.
      out_ready = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         in_valid = 1'b1;
         A = 16'h1111 * 16'(next);
         B = 16'h0F0F + 16'(next);
         Bin = next[0];
         in_tag = 4'(next);
         @(negedge clk);
         if (!in_ready || !out_valid) bad++;
         if (in_ready) next++;
         cyc();
      end
      chk("fullrate_gaps", 32'(bad), 32'd0);
      chk("fullrate_accepts", 32'(next), 32'd103);
      idle_inputs();
      for (int c = 0; c < 10 && sb.size() != 0; c++) cyc();
      chk("bp_drain", 32'(sb.size()), 32'd0);
      cyc();

      // Reset with three ops in flight.
      out_ready = 1'b0;
      push_op(16'hAAAA, 16'h0001, 1'b0, 4'h1);
      push_op(16'hBBBB, 16'h0002, 1'b0, 4'h2);
      push_op(16'hCCCC, 16'h0003, 1'b0, 4'h3);
      cyc();
      chk("mid_full_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_diff", 32'(Diff), 32'd0);
      chk("mid_rst_tag", 32'(out_tag), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;
      cyc();
      chk("mid_no_stale", 32'(out_valid), 32'd0);
      push_op(16'h0100, 16'h0001, 1'b1, 4'hE);
      chk("mid_lat_e0", 32'(out_valid), 32'd0);
      cyc();
      chk("mid_lat_e1", 32'(out_valid), 32'd0);
      cyc();
      chk("mid_lat_valid", 32'(out_valid), 32'd1);
      chk("mid_lat_tag", 32'(out_tag), 32'hE);
      chk("mid_lat_diff", 32'(Diff), 32'h000FE);
      cyc();

      // Random in_valid / out_ready handshake.
      n_in = 0;
      n_out = 0;
      sent = 0;
      acc = 1'b0;
      for (int c = 0; c < 40000 && sent < 3000; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid || acc) begin
            if ($urandom_range(0, 1) == 1) begin
               in_valid = 1'b1;
               A = 16'($urandom);
               B = 16'($urandom);
               Bin = 1'($urandom_range(0, 1));
               in_tag = 4'(sent);
            end else begin
               idle_inputs();
            end
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) sent++;
         cyc();
      end
      idle_inputs();
      out_ready = 1'b1;
      for (int c = 0; c < 10 && sb.size() != 0; c++) cyc();
      chk("rnd_sent", 32'(sent), 32'd3000);
      chk("rnd_drain", 32'(sb.size()), 32'd0);
      chk("rnd_in_eq_out", 32'(n_out), 32'(n_in));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
